// File: rtl/picorv_pcpi_issue_pkg.sv
// Shared definitions for the PCPI issue stage: FSM states, instruction field offsets
// and the prefix encoding that marks a 4-byte instruction.
package picorv_pcpi_issue_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_TRAP   = 2'd3
    } state_t;

    localparam int unsigned REG_AW  = 5;
    localparam int unsigned RD_LSB  = 7;
    localparam int unsigned RS1_LSB = 15;
    localparam int unsigned RS2_LSB = 20;
    localparam int unsigned RS3_LSB = 27;

    localparam logic [1:0] PREFIX_LEN32 = 2'b11;

    // Byte length of an instruction from the low prefix bits.
    function automatic logic [2:0] insn_bytes(input logic [1:0] len);
        return (len == PREFIX_LEN32) ? 3'd4 : 3'd2;
    endfunction

endpackage

// File: rtl/picorv_pcpi_issue_timer.sv
// Counts EXEC cycles since the last decode; flags the cycle in which the limit is reached.
module picorv_pcpi_issue_timer
    import picorv_pcpi_issue_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    // Fires during the TIMEOUT-th enabled cycle; TIMEOUT of zero never fires.
    assign expired_c = (TIMEOUT != 0) && enable && (count == LAST);

endmodule

// File: rtl/picorv_pcpi_issue.sv
// PCPI initiator: takes one fetched instruction at a time, broadcasts decode, presents
// operands until a responder is ready, then retires (writeback, PC update, redirect) or traps.
module picorv_pcpi_issue
    import picorv_pcpi_issue_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     ILEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     TIMEOUT  = 15,
    parameter bit              RS3_EN   = 1'b0
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                fetch_valid,
    output logic                fetch_ready,
    input  logic [ILEN-1:0]     fetch_insn,
    input  logic [15:0]         fetch_prefix,
    output logic [XLEN-1:0]     fetch_pc,
    output logic                fetch_redirect,
    output logic                decode_valid,
    output logic [ILEN-1:0]     decode_insn,
    output logic [15:0]         decode_prefix,
    output logic                pcpi_valid,
    output logic [ILEN-1:0]     pcpi_insn,
    output logic [15:0]         pcpi_prefix,
    output logic [XLEN-1:0]     pcpi_pc,
    output logic                pcpi_rs1_valid,
    output logic                pcpi_rs2_valid,
    output logic                pcpi_rs3_valid,
    output logic [XLEN-1:0]     pcpi_rs1_data,
    output logic [XLEN-1:0]     pcpi_rs2_data,
    output logic [XLEN-1:0]     pcpi_rs3_data,
    input  logic                pcpi_ready,
    output logic                pcpi_wb_valid,
    input  logic                pcpi_wb_write,
    input  logic [XLEN-1:0]     pcpi_wb_data,
    input  logic                pcpi_br_enable,
    input  logic [XLEN-1:0]     pcpi_br_nextpc,
    output logic [REG_AW-1:0]   rf_raddr1,
    output logic [REG_AW-1:0]   rf_raddr2,
    output logic [REG_AW-1:0]   rf_raddr3,
    input  logic [XLEN-1:0]     rf_rdata1,
    input  logic [XLEN-1:0]     rf_rdata2,
    input  logic [XLEN-1:0]     rf_rdata3,
    output logic                rf_wen,
    output logic [REG_AW-1:0]   rf_waddr,
    output logic [XLEN-1:0]     rf_wdata,
    output logic                retire,
    output logic                trap
);

    state_t              state;
    logic [ILEN-1:0]     insn_q;
    logic [15:0]         prefix_q;
    logic [XLEN-1:0]     pc_q;
    logic                exec_q;
    logic [REG_AW-1:0]   rd;
    logic                expired_c;

    assign rd = insn_q[RD_LSB +: REG_AW];

    picorv_pcpi_issue_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clock     (clock),
        .resetn    (resetn),
        .clear     (state == ST_DECODE),
        .enable    (state == ST_EXEC),
        .expired_c (expired_c)
    );

    // Latched instruction feeds both the decode broadcast and the operand phase.
    assign decode_insn    = insn_q;
    assign decode_prefix  = prefix_q;
    assign pcpi_insn      = insn_q;
    assign pcpi_prefix    = prefix_q;
    assign pcpi_pc        = pc_q;
    assign pcpi_valid     = exec_q;
    assign pcpi_rs1_valid = exec_q;
    assign pcpi_rs2_valid = exec_q;
    assign pcpi_rs3_valid = exec_q & RS3_EN;
    assign pcpi_wb_valid  = exec_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state          <= ST_IDLE;
            fetch_ready    <= 1'b0;
            fetch_pc       <= RESET_PC;
            fetch_redirect <= 1'b0;
            decode_valid   <= 1'b0;
            insn_q         <= '0;
            prefix_q       <= '0;
            pc_q           <= '0;
            exec_q         <= 1'b0;
            pcpi_rs1_data  <= '0;
            pcpi_rs2_data  <= '0;
            pcpi_rs3_data  <= '0;
            rf_raddr1      <= '0;
            rf_raddr2      <= '0;
            rf_raddr3      <= '0;
            rf_wen         <= 1'b0;
            rf_waddr       <= '0;
            rf_wdata       <= '0;
            retire         <= 1'b0;
            trap           <= 1'b0;
        end else begin
            decode_valid   <= 1'b0;
            retire         <= 1'b0;
            fetch_redirect <= 1'b0;
            rf_wen         <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fetch_valid && fetch_ready) begin
                        state        <= ST_DECODE;
                        fetch_ready  <= 1'b0;
                        decode_valid <= 1'b1;
                        insn_q       <= fetch_insn;
                        prefix_q     <= fetch_prefix;
                        pc_q         <= fetch_pc;
                        rf_raddr1    <= fetch_insn[RS1_LSB +: REG_AW];
                        rf_raddr2    <= fetch_insn[RS2_LSB +: REG_AW];
                        rf_raddr3    <= RS3_EN ? fetch_insn[RS3_LSB +: REG_AW] : '0;
                    end else begin
                        fetch_ready  <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    // Register read data follows the address presented during decode.
                    state         <= ST_EXEC;
                    exec_q        <= 1'b1;
                    pcpi_rs1_data <= rf_rdata1;
                    pcpi_rs2_data <= rf_rdata2;
                    pcpi_rs3_data <= RS3_EN ? rf_rdata3 : '0;
                end
                ST_EXEC: begin
                    if (pcpi_ready) begin
                        state          <= ST_IDLE;
                        exec_q         <= 1'b0;
                        fetch_ready    <= 1'b1;
                        retire         <= 1'b1;
                        rf_wen         <= pcpi_wb_write && (rd != '0);
                        rf_waddr       <= rd;
                        rf_wdata       <= pcpi_wb_data;
                        fetch_redirect <= pcpi_br_enable;
                        fetch_pc       <= pcpi_br_enable ? (pcpi_br_nextpc & ~XLEN'(1))
                                                         : pc_q + XLEN'(insn_bytes(prefix_q[1:0]));
                    end else if (expired_c) begin
                        state  <= ST_TRAP;
                        exec_q <= 1'b0;
                        trap   <= 1'b1;
                    end
                end
                default: begin
                    trap <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_picorv_pcpi_issue.sv
// Directed and randomized instruction stream against a reference PC/register-file model.
module tb_picorv_pcpi_issue;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned ILEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned TIMEOUT  = 15;

    logic              clock;
    logic              resetn;
    logic              fetch_valid;
    logic              fetch_ready;
    logic [ILEN-1:0]   fetch_insn;
    logic [15:0]       fetch_prefix;
    logic [XLEN-1:0]   fetch_pc;
    logic              fetch_redirect;
    logic              decode_valid;
    logic [ILEN-1:0]   decode_insn;
    logic [15:0]       decode_prefix;
    logic              pcpi_valid;
    logic [ILEN-1:0]   pcpi_insn;
    logic [15:0]       pcpi_prefix;
    logic [XLEN-1:0]   pcpi_pc;
    logic              pcpi_rs1_valid, pcpi_rs2_valid, pcpi_rs3_valid;
    logic [XLEN-1:0]   pcpi_rs1_data, pcpi_rs2_data, pcpi_rs3_data;
    logic              pcpi_ready;
    logic              pcpi_wb_valid;
    logic              pcpi_wb_write;
    logic [XLEN-1:0]   pcpi_wb_data;
    logic              pcpi_br_enable;
    logic [XLEN-1:0]   pcpi_br_nextpc;
    logic [4:0]        rf_raddr1, rf_raddr2, rf_raddr3;
    logic [XLEN-1:0]   rf_rdata1, rf_rdata2, rf_rdata3;
    logic              rf_wen;
    logic [4:0]        rf_waddr;
    logic [XLEN-1:0]   rf_wdata;
    logic              retire;
    logic              trap;

    int total = 0;
    int bad   = 0;

    logic [31:0] regs     [32] = '{default: '0};
    logic [31:0] ref_regs [32] = '{default: '0};
    logic [31:0] exp_pc;

    picorv_pcpi_issue #(
        .XLEN(XLEN), .ILEN(ILEN), .RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT), .RS3_EN(1'b0)
    ) dut (
        .clock(clock), .resetn(resetn),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_insn(fetch_insn),
        .fetch_prefix(fetch_prefix), .fetch_pc(fetch_pc), .fetch_redirect(fetch_redirect),
        .decode_valid(decode_valid), .decode_insn(decode_insn), .decode_prefix(decode_prefix),
        .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_prefix(pcpi_prefix), .pcpi_pc(pcpi_pc),
        .pcpi_rs1_valid(pcpi_rs1_valid), .pcpi_rs2_valid(pcpi_rs2_valid), .pcpi_rs3_valid(pcpi_rs3_valid),
        .pcpi_rs1_data(pcpi_rs1_data), .pcpi_rs2_data(pcpi_rs2_data), .pcpi_rs3_data(pcpi_rs3_data),
        .pcpi_ready(pcpi_ready), .pcpi_wb_valid(pcpi_wb_valid), .pcpi_wb_write(pcpi_wb_write),
        .pcpi_wb_data(pcpi_wb_data), .pcpi_br_enable(pcpi_br_enable), .pcpi_br_nextpc(pcpi_br_nextpc),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_raddr3(rf_raddr3),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .rf_rdata3(rf_rdata3),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .retire(retire), .trap(trap)
    );

    always #5 clock = ~clock;

    // Register file: data follows the registered read address; writes land on the clock edge.
    assign rf_rdata1 = regs[rf_raddr1];
    assign rf_rdata2 = regs[rf_raddr2];
    assign rf_rdata3 = regs[rf_raddr3];
    always @(posedge clock) if (rf_wen) regs[rf_waddr] <= rf_wdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        logic any;
        any = |{fetch_ready, fetch_redirect, decode_valid, decode_insn, decode_prefix,
                pcpi_valid, pcpi_insn, pcpi_prefix, pcpi_pc, pcpi_rs1_valid, pcpi_rs2_valid,
                pcpi_rs3_valid, pcpi_rs1_data, pcpi_rs2_data, pcpi_rs3_data, pcpi_wb_valid,
                rf_raddr1, rf_raddr2, rf_raddr3, rf_wen, rf_waddr, rf_wdata, retire, trap};
        chk({tag, "_fetch_pc"}, 64'(fetch_pc), 64'(RESET_PC));
        chk({tag, "_outputs_zero"}, 64'(any), 64'd0);
    endtask

    // mode 0: normal retire, 1: reset asserted while ready is offered, 2: never ready (trap)
    task automatic issue(input logic [31:0] insn, input logic [15:0] prefix, input int delay,
                         input int mode, input logic wbw, input logic [31:0] wbd,
                         input logic br, input logic [31:0] npc, input logic dec_ready);
        int n;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] pc_now, pc_next;
        logic        exp_wen;
        rs1 = insn[19:15];
        rs2 = insn[24:20];
        rd  = insn[11:7];
        pc_now = exp_pc;
        n = 0;
        while (fetch_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("fetch_ready_wait", 64'(fetch_ready), 64'd1);
        if (fetch_ready !== 1'b1) return;
        fetch_valid  = 1'b1;
        fetch_insn   = insn;
        fetch_prefix = prefix;
        tick();
        fetch_valid  = 1'b0;
        fetch_insn   = $urandom;
        fetch_prefix = 16'($urandom);

        chk("dec_valid", 64'(decode_valid), 64'd1);
        chk("dec_insn", 64'(decode_insn), 64'(insn));
        chk("dec_prefix", 64'(decode_prefix), 64'(prefix));
        chk("dec_raddr", 64'({rf_raddr1, rf_raddr2, rf_raddr3}), 64'({rs1, rs2, 5'd0}));
        chk("dec_quiet", 64'({retire, fetch_redirect, fetch_ready, pcpi_valid, rf_wen}), 64'd0);
        chk("dec_fetch_pc", 64'(fetch_pc), 64'(pc_now));
        pcpi_ready    = dec_ready;
        pcpi_wb_write = dec_ready;
        pcpi_wb_data  = $urandom;
        tick();

        pcpi_ready    = 1'b0;
        pcpi_wb_write = 1'b0;
        chk("exec_flags", 64'({pcpi_valid, pcpi_rs1_valid, pcpi_rs2_valid, pcpi_rs3_valid,
                              pcpi_wb_valid, decode_valid, retire}), 64'(7'b1110100));
        chk("exec_rs1", 64'(pcpi_rs1_data), 64'(ref_regs[rs1]));
        chk("exec_rs2", 64'(pcpi_rs2_data), 64'(ref_regs[rs2]));
        chk("exec_rs3", 64'(pcpi_rs3_data), 64'd0);
        chk("exec_pc", 64'(pcpi_pc), 64'(pc_now));
        chk("exec_insn", 64'(pcpi_insn), 64'(insn));

        if (mode == 2) begin
            for (int k = 1; k < int'(TIMEOUT); k++) begin
                pcpi_wb_write = 1'($urandom);
                tick();
            end
            chk("trap_last_exec", 64'({trap, pcpi_valid}), 64'b01);
            tick();
            chk("trap_set", 64'({trap, pcpi_valid, fetch_ready, retire}), 64'b1000);
            chk("trap_fetch_pc", 64'(fetch_pc), 64'(pc_now));
            pcpi_ready    = 1'b1;
            pcpi_wb_write = 1'b1;
            repeat (3) tick();
            chk("trap_sticky", 64'({trap, pcpi_valid, fetch_ready, retire, rf_wen}), 64'b10000);
            chk("trap_hold_pc", 64'(fetch_pc), 64'(pc_now));
            pcpi_ready    = 1'b0;
            pcpi_wb_write = 1'b0;
            return;
        end

        for (int k = 0; k < delay; k++) begin
            pcpi_wb_write  = 1'($urandom);
            pcpi_wb_data   = $urandom;
            pcpi_br_enable = 1'($urandom);
            tick();
        end
        chk("exec_wait_no_retire", 64'({retire, rf_wen, trap, pcpi_valid}), 64'b0001);
        pcpi_ready     = 1'b1;
        pcpi_wb_write  = wbw;
        pcpi_wb_data   = wbd;
        pcpi_br_enable = br;
        pcpi_br_nextpc = npc;

        if (mode == 1) begin
            resetn = 1'b0;
            tick();
            pcpi_ready     = 1'b0;
            pcpi_wb_write  = 1'b0;
            pcpi_br_enable = 1'b0;
            check_reset_state("rst_exec");
            tick();
            chk("rst_exec_no_rf_write", 64'(regs[rd]), 64'(ref_regs[rd]));
            exp_pc = RESET_PC;
            resetn = 1'b1;
            return;
        end

        tick();
        pcpi_ready     = 1'b0;
        pcpi_wb_write  = 1'b0;
        pcpi_br_enable = 1'b0;
        pc_next = br ? (npc & ~32'h1) : pc_now + ((prefix[1:0] == 2'b11) ? 32'd4 : 32'd2);
        exp_wen = wbw && (rd != 5'd0);
        chk("ret_retire", 64'({retire, pcpi_valid, trap}), 64'b100);
        chk("ret_fetch_pc", 64'(fetch_pc), 64'(pc_next));
        chk("ret_redirect", 64'(fetch_redirect), 64'(br));
        chk("ret_rf_wen", 64'(rf_wen), 64'(exp_wen));
        if (exp_wen) chk("ret_rf_write", 64'({rf_waddr, rf_wdata}), 64'({rd, wbd}));
        if (exp_wen) ref_regs[rd] = wbd;
        exp_pc = pc_next;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        clock = 1'b0;
        resetn = 1'b0;
        fetch_valid = 1'b0;
        fetch_insn = '0;
        fetch_prefix = '0;
        pcpi_ready = 1'b0;
        pcpi_wb_write = 1'b0;
        pcpi_wb_data = '0;
        pcpi_br_enable = 1'b0;
        pcpi_br_nextpc = '0;
        exp_pc = RESET_PC;

        repeat (2) tick();
        check_reset_state("reset");
        resetn = 1'b1;
        tick();

        // ADDI x1,x0,5 with the responder ready one cycle after valid
        issue(32'h0050_0093, 16'h0003, 1, 0, 1'b1, 32'd5, 1'b0, 32'h0, 1'b0);
        tick();
        chk("addi_x1", 64'(regs[1]), 64'd5);

        // JAL x1 taken to an odd target: low bit dropped, redirect pulses
        issue(32'h0000_00EF, 16'h0003, 0, 0, 1'b1, 32'd4, 1'b1, 32'h0000_0101, 1'b1);
        chk("jal_pc", 64'(fetch_pc), 64'h100);

        // Writeback to x0 is suppressed
        issue(32'h0000_0013, 16'h0003, 2, 0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);

        // Branch to the top of the address space, then a 2-byte insn wraps to zero
        issue(32'h0000_006F, 16'h0003, 0, 0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        issue(32'h0000_0001, 16'h0001, 0, 0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("wrap_pc", 64'(fetch_pc), 64'h0);

        for (int i = 0; i < 40; i++) begin
            issue($urandom, 16'($urandom), int'($urandom_range(0, 6)), 0, 1'($urandom),
                  $urandom, ($urandom_range(0, 3) == 0), $urandom, 1'($urandom));
        end

        // Ready in the very cycle the timeout is reached: retire wins
        issue($urandom, 16'h0003, int'(TIMEOUT) - 1, 0, 1'b1, $urandom, 1'b0, 32'h0, 1'b0);
        chk("timeout_edge_no_trap", 64'(trap), 64'd0);

        // Reset while a responder offers writeback
        issue(32'h00A0_0113, 16'h0003, 1, 1, 1'b1, 32'd10, 1'b0, 32'h0, 1'b0);

        // No responder claims the instruction
        issue(32'h0000_0000 | $urandom, 16'h0003, 0, 2, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

        resetn = 1'b0;
        tick();
        check_reset_state("final_reset");
        resetn = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
